// File: rtl/bus_rv32_ch_bridge_pkg.sv
`default_nettype none
// ============================================================================
// cpu_reg_package : shared types and constants for the channel bridge
// Rev 1.0 - initial release
// ============================================================================
package cpu_reg_package;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } bridge_state_t;

  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_rv32_ch_bridge_if.sv
`default_nettype none
// ============================================================================
// bus_rv32_ch_bridge_if : CPU-side and channel-side signals of the bridge
// Rev 1.0 - initial release
// ============================================================================
interface bus_rv32_ch_bridge_if #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]        cpu_addr_i;
  logic [DATA_W-1:0]        cpu_data_i;
  logic                     cpu_we_i;
  logic                     cpu_re_i;
  logic [DATA_W-1:0]        cpu_rdata_o;
  logic                     cpu_halt_o;
  logic                     cpu_err_o;
  logic [ADDR_W-1:0]        ch_addr_o;
  logic [DATA_W-1:0]        ch_data_o;
  logic [NUM_CH-1:0]        ch_we_o;
  logic [NUM_CH-1:0]        ch_re_o;
  logic [NUM_CH*DATA_W-1:0] ch_rdata_i;
  logic [NUM_CH-1:0]        ch_busy_i;

  // Bridge view
  modport slave (
    input  cpu_addr_i, cpu_data_i, cpu_we_i, cpu_re_i, ch_rdata_i, ch_busy_i,
    output cpu_rdata_o, cpu_halt_o, cpu_err_o, ch_addr_o, ch_data_o, ch_we_o, ch_re_o
  );

  // Environment view (CPU plus channel modules)
  modport master (
    output cpu_addr_i, cpu_data_i, cpu_we_i, cpu_re_i, ch_rdata_i, ch_busy_i,
    input  cpu_rdata_o, cpu_halt_o, cpu_err_o, ch_addr_o, ch_data_o, ch_we_o, ch_re_o
  );
endinterface
`default_nettype wire

// File: rtl/bus_rv32_ch_decode.sv
`default_nettype none
// ============================================================================
// bus_rv32_ch_decode : region hit and channel index decode of a CPU address
// Rev 1.0 - initial release
// ============================================================================
module bus_rv32_ch_decode
  import cpu_reg_package::*;
#(
  parameter int                NUM_CH    = 4,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h0000_9000),
  parameter int                SEL_LSB   = 8,
  localparam int               CH_W      = ch_width(NUM_CH)
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic              hit_o,
  output logic [CH_W-1:0]   ch_o
);

  logic w_region;
  logic w_in_range;

  assign w_region = ((addr_i >> (SEL_LSB + CH_W)) == (BASE_ADDR >> (SEL_LSB + CH_W)));
  assign ch_o     = addr_i[SEL_LSB +: CH_W];

  // A full power-of-two channel set has no unused select codes
  if (NUM_CH == (1 << CH_W)) begin : g_full
    assign w_in_range = 1'b1;
  end else begin : g_part
    assign w_in_range = ({1'b0, ch_o} < (CH_W+1)'(NUM_CH));
  end

  assign hit_o = w_region & w_in_range;

endmodule
`default_nettype wire

// File: rtl/bus_rv32_ch_bridge.sv
`default_nettype none
// ============================================================================
// bus_rv32_ch_bridge : stalls the CPU while one access is forwarded to one of
// NUM_CH busy-handshaked channels, with a stall timeout. Rev 1.0
// ============================================================================
module bus_rv32_ch_bridge
  import cpu_reg_package::*;
#(
  parameter int                NUM_CH    = 4,
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h0000_9000),
  parameter int                SEL_LSB   = 8,
  parameter int                TIMEOUT   = 255
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  bus_rv32_ch_bridge_if.slave  bus
);

  localparam int          CH_W      = ch_width(NUM_CH);
  localparam logic [15:0] C_TIMEOUT = 16'(TIMEOUT);

  bridge_state_t     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              we_q, we_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              err_q, err_d;

  logic              w_hit;
  logic [CH_W-1:0]   w_dec_ch;
  logic              w_busy_sel;
  logic [DATA_W-1:0] w_rdata_sel;
  logic              w_strobe;
  logic              w_halt;
  logic              w_timeout;
  logic [15:0]       w_cnt_inc;
  logic [NUM_CH-1:0] w_we;
  logic [NUM_CH-1:0] w_re;

  bus_rv32_ch_decode #(
    .NUM_CH    (NUM_CH),
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR),
    .SEL_LSB   (SEL_LSB)
  ) u_decode (
    .addr_i (bus.cpu_addr_i),
    .hit_o  (w_hit),
    .ch_o   (w_dec_ch)
  );

  always_comb begin
    w_busy_sel  = 1'b0;
    w_rdata_sel = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_q == CH_W'(k)) begin
        w_busy_sel  = bus.ch_busy_i[k];
        w_rdata_sel = bus.ch_rdata_i[k*DATA_W +: DATA_W];
      end
    end
  end

  assign w_cnt_inc = cnt_q + 16'd1;
  assign w_timeout = (w_cnt_inc == C_TIMEOUT);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    we_d     = we_q;
    ch_d     = ch_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    err_d    = 1'b0;
    w_strobe = 1'b0;
    w_halt   = 1'b0;
    case (state_q)
      IDLE: begin
        if ((bus.cpu_we_i | bus.cpu_re_i) && w_hit) begin
          w_halt  = 1'b1;
          addr_d  = bus.cpu_addr_i;
          data_d  = bus.cpu_data_i;
          we_d    = bus.cpu_we_i;
          ch_d    = w_dec_ch;
          cnt_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        w_halt = 1'b1;
        cnt_d  = w_cnt_inc;
        if (!w_busy_sel) begin
          w_strobe = 1'b1;
          state_d  = WAIT;
        end else if (w_timeout) begin
          err_d   = 1'b1;
          rdata_d = we_q ? rdata_q : DATA_W'(ERR_DATA);
          state_d = DONE;
        end
      end
      WAIT: begin
        w_halt = 1'b1;
        cnt_d  = w_cnt_inc;
        if (!w_busy_sel) begin
          rdata_d = we_q ? rdata_q : w_rdata_sel;
          state_d = DONE;
        end else if (w_timeout) begin
          err_d   = 1'b1;
          rdata_d = we_q ? rdata_q : DATA_W'(ERR_DATA);
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      ch_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    w_we = '0;
    w_re = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_we[k] = w_strobe &  we_q & (ch_q == CH_W'(k));
      w_re[k] = w_strobe & ~we_q & (ch_q == CH_W'(k));
    end
  end

  // Halt in IDLE follows the CPU inputs, so it is masked while reset is held
  assign bus.cpu_halt_o  = w_halt & reset_i;
  assign bus.cpu_err_o   = err_q;
  assign bus.cpu_rdata_o = rdata_q;
  assign bus.ch_addr_o   = addr_q;
  assign bus.ch_data_o   = data_q;
  assign bus.ch_we_o     = w_we;
  assign bus.ch_re_o     = w_re;

endmodule
`default_nettype wire

// File: tb/tb_bus_rv32_ch_bridge.sv
`default_nettype none
// ============================================================================
// tb_bus_rv32_ch_bridge : directed vector table plus stall, timeout and
// mid-transaction reset sequences. Rev 1.0
// ============================================================================
module tb_bus_rv32_ch_bridge;

  logic clk_i;
  logic reset_i;
  int   checks;
  int   failures;

  bus_rv32_ch_bridge_if #(.NUM_CH(4), .ADDR_W(32), .DATA_W(32)) bus ();

  bus_rv32_ch_bridge #(
    .NUM_CH    (4),
    .ADDR_W    (32),
    .DATA_W    (32),
    .BASE_ADDR (32'h0000_9000),
    .SEL_LSB   (8),
    .TIMEOUT   (10)
  ) u_dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        we;
    logic        re;
    logic        hit;
    logic [3:0]  exp_we;
    logic [3:0]  exp_re;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".halt"},  {31'd0, bus.cpu_halt_o}, 32'd0);
    chk({tag, ".err"},   {31'd0, bus.cpu_err_o},  32'd0);
    chk({tag, ".rdata"}, bus.cpu_rdata_o,         32'd0);
    chk({tag, ".addr"},  bus.ch_addr_o,           32'd0);
    chk({tag, ".data"},  bus.ch_data_o,           32'd0);
    chk({tag, ".we"},    {28'd0, bus.ch_we_o},    32'd0);
    chk({tag, ".re"},    {28'd0, bus.ch_re_o},    32'd0);
  endtask

  // Single transaction against never-busy channels: request in T, checks in T..T+3
  task automatic apply_vec(input vec_t v, input string tag);
    next_cycle();
    bus.cpu_addr_i = v.addr;
    bus.cpu_data_i = v.data;
    bus.cpu_we_i   = v.we;
    bus.cpu_re_i   = v.re;
    @(negedge clk_i);
    chk({tag, ".halt_T"}, {31'd0, bus.cpu_halt_o}, {31'd0, v.hit});
    next_cycle();
    bus.cpu_we_i = 1'b0;
    bus.cpu_re_i = 1'b0;
    @(negedge clk_i);
    chk({tag, ".we_T1"},   {28'd0, bus.ch_we_o},    {28'd0, v.exp_we});
    chk({tag, ".re_T1"},   {28'd0, bus.ch_re_o},    {28'd0, v.exp_re});
    chk({tag, ".halt_T1"}, {31'd0, bus.cpu_halt_o}, {31'd0, v.hit});
    if (v.hit) begin
      chk({tag, ".ch_addr"}, bus.ch_addr_o, v.addr);
      chk({tag, ".ch_data"}, bus.ch_data_o, v.data);
    end
    next_cycle();
    @(negedge clk_i);
    chk({tag, ".strobe_T2"}, {28'd0, bus.ch_we_o | bus.ch_re_o}, 32'd0);
    chk({tag, ".halt_T2"},   {31'd0, bus.cpu_halt_o}, {31'd0, v.hit});
    next_cycle();
    @(negedge clk_i);
    chk({tag, ".halt_T3"}, {31'd0, bus.cpu_halt_o}, 32'd0);
    chk({tag, ".rdata"},   bus.cpu_rdata_o, v.exp_rdata);
    chk({tag, ".err"},     {31'd0, bus.cpu_err_o}, 32'd0);
  endtask

  initial begin
    int strb;
    int errc;
    int err_cyc;
    logic halt_at_err;

    checks   = 0;
    failures = 0;
    reset_i  = 1'b0;
    bus.cpu_addr_i = '0;
    bus.cpu_data_i = '0;
    bus.cpu_we_i   = 1'b0;
    bus.cpu_re_i   = 1'b0;
    bus.ch_busy_i  = '0;
    bus.ch_rdata_i = {32'h3333_3333, 32'h2222_2222, 32'h1234_5678, 32'h0BAD_F00D};

    //           addr           data           we    re    hit   exp_we   exp_re   exp_rdata
    vecs[0] = '{32'h0000_9100, 32'h0000_0011, 1'b0, 1'b1, 1'b1, 4'b0000, 4'b0010, 32'h1234_5678};
    vecs[1] = '{32'h0000_9000, 32'h0000_0022, 1'b0, 1'b1, 1'b1, 4'b0000, 4'b0001, 32'h0BAD_F00D};
    vecs[2] = '{32'h0000_9300, 32'hA5A5_A5A5, 1'b1, 1'b0, 1'b1, 4'b1000, 4'b0000, 32'h0BAD_F00D};
    vecs[3] = '{32'h0000_8000, 32'h0000_0033, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 32'h0BAD_F00D};
    vecs[4] = '{32'h0000_9200, 32'h5A5A_0042, 1'b1, 1'b1, 1'b1, 4'b0100, 4'b0000, 32'h0BAD_F00D};
    vecs[5] = '{32'h0000_93FC, 32'h0000_0055, 1'b0, 1'b1, 1'b1, 4'b0000, 4'b1000, 32'h3333_3333};
    vecs[6] = '{32'h0000_9400, 32'h0000_0066, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 32'h3333_3333};
    vecs[7] = '{32'h0001_9100, 32'h0000_0077, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 32'h3333_3333};
    vecs[8] = '{32'h0000_9200, 32'h0000_0088, 1'b0, 1'b1, 1'b1, 4'b0000, 4'b0100, 32'h2222_2222};

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_all_zero("reset");
    next_cycle();
    reset_i = 1'b1;

    for (int i = 0; i < 9; i++) begin
      apply_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Write to ch3, which stays busy for five cycles after the strobe
    strb = 0;
    errc = 0;
    for (int c = 0; c < 10; c++) begin
      next_cycle();
      bus.cpu_addr_i = 32'h0000_9300;
      bus.cpu_data_i = 32'hA5A5_A5A5;
      bus.cpu_we_i   = (c == 0);
      bus.ch_busy_i  = (c >= 2 && c <= 6) ? 4'b1000 : 4'b0000;
      @(negedge clk_i);
      chk($sformatf("stall.halt_c%0d", c), {31'd0, bus.cpu_halt_o}, (c <= 7) ? 32'd1 : 32'd0);
      strb += $countones(bus.ch_we_o | bus.ch_re_o);
      if (bus.cpu_err_o) errc++;
      if (c == 1) chk("stall.we_T1", {28'd0, bus.ch_we_o}, 32'h8);
    end
    chk("stall.strobes", strb, 32'd1);
    chk("stall.errs",    errc, 32'd0);
    chk("stall.rdata",   bus.cpu_rdata_o, 32'h2222_2222);

    // Read from permanently busy ch0 must time out
    strb        = 0;
    errc        = 0;
    err_cyc     = -1;
    halt_at_err = 1'b1;
    for (int c = 0; c < 30; c++) begin
      next_cycle();
      bus.cpu_addr_i = 32'h0000_9000;
      bus.cpu_re_i   = (c == 0);
      bus.ch_busy_i  = 4'b0001;
      @(negedge clk_i);
      strb += $countones(bus.ch_we_o | bus.ch_re_o);
      if (bus.cpu_err_o) begin
        errc++;
        if (err_cyc < 0) begin
          err_cyc     = c;
          halt_at_err = bus.cpu_halt_o;
        end
      end
    end
    chk("tmo.err_pulses", errc, 32'd1);
    chk("tmo.strobes",    strb, 32'd0);
    chk("tmo.err_cycle_in_window", {31'd0, (err_cyc >= 10 && err_cyc <= 12)}, 32'd1);
    chk("tmo.halt_at_err", {31'd0, halt_at_err}, 32'd0);
    chk("tmo.rdata",       bus.cpu_rdata_o, 32'hDEAD_BEEF);
    chk("tmo.halt_end",    {31'd0, bus.cpu_halt_o}, 32'd0);
    next_cycle();
    bus.ch_busy_i = 4'b0000;

    // Reset asserted while the bridge waits on a busy ch1
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      bus.cpu_addr_i = 32'h0000_9100;
      bus.cpu_re_i   = (c == 0);
      bus.ch_busy_i  = (c >= 2) ? 4'b0010 : 4'b0000;
      if (c == 3) begin
        chk("rst.halt_before", {31'd0, bus.cpu_halt_o}, 32'd1);
        #1;
        reset_i = 1'b0;
        #1;
        check_all_zero("rst.same_cycle");
      end
    end
    @(negedge clk_i);
    check_all_zero("rst.held");
    next_cycle();
    bus.ch_busy_i = 4'b0000;
    next_cycle();
    reset_i = 1'b1;
    apply_vec(vecs[0], "rst.after");
    chk("rst.err_after", {31'd0, bus.cpu_err_o}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/bus_rv32_ch_bridge.md
BUS_RV32_CH_BRIDGE -- requirements
Module: bus_rv32_ch_bridge

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of downstream channels, 1..16.
REQ-002 SHALL have parameter ADDR_W, default 32: address width.
REQ-003 SHALL have parameter DATA_W, default 32: data width.
REQ-004 SHALL have parameter BASE_ADDR, default 32'h0000_9000: region base address.
REQ-005 SHALL have parameter SEL_LSB, default 8: lowest address bit of the channel-select field; CH_W = max(1, clog2(NUM_CH)).
REQ-006 SHALL have parameter TIMEOUT, default 255: maximum stall cycles before error, 1..65535.
REQ-007 SHALL have port clk_i, input, 1 bit: single clock; all logic on its rising edge.
REQ-008 SHALL have port reset_i, input, 1 bit: reset, asynchronous assert, active-low.
REQ-009 SHALL have port cpu_addr_i, input, ADDR_W bits: CPU address.
REQ-010 SHALL have port cpu_data_i, input, DATA_W bits: CPU write data.
REQ-011 SHALL have port cpu_we_i, input, 1 bit: write request.
REQ-012 SHALL have port cpu_re_i, input, 1 bit: read request.
REQ-013 SHALL have port cpu_rdata_o, output, DATA_W bits: registered read data.
REQ-014 SHALL have port cpu_halt_o, output, 1 bit: CPU stall.
REQ-015 SHALL have port cpu_err_o, output, 1 bit: one-cycle timeout error pulse.
REQ-016 SHALL have port ch_addr_o, output, ADDR_W bits: latched address, shared by all channels.
REQ-017 SHALL have port ch_data_o, output, DATA_W bits: latched write data, shared.
REQ-018 SHALL have port ch_we_o, output, NUM_CH bits: per-channel write strobe.
REQ-019 SHALL have port ch_re_o, output, NUM_CH bits: per-channel read strobe.
REQ-020 SHALL have port ch_rdata_i, input, NUM_CH*DATA_W bits: per-channel read data; channel k at [k*DATA_W +: DATA_W].
REQ-021 SHALL have port ch_busy_i, input, NUM_CH bits: per-channel module busy.

Function
REQ-022 Hit SHALL be (cpu_addr_i >> (SEL_LSB+CH_W)) == (BASE_ADDR >> (SEL_LSB+CH_W)); channel = cpu_addr_i[SEL_LSB +: CH_W]; a channel index >= NUM_CH SHALL count as a miss.
REQ-023 FSM states SHALL be IDLE, ISSUE, WAIT, DONE.
REQ-024 IDLE: when (cpu_we_i|cpu_re_i) and hit, SHALL latch address, data, op and channel, and go to ISSUE; if both requests are high, write SHALL win. A miss SHALL be ignored, with no halt.
REQ-025 cpu_halt_o SHALL be combinational: high in IDLE on a hit request, and high throughout ISSUE and WAIT; low in DONE and otherwise.
REQ-026 ISSUE: if ch_busy_i[ch]=0, SHALL pulse exactly one bit of ch_we_o or ch_re_o for one cycle, then go to WAIT; otherwise stay in ISSUE.
REQ-027 WAIT: if ch_busy_i[ch]=0, SHALL capture ch_rdata_i[ch] into cpu_rdata_o (reads only) and go to DONE.
REQ-028 DONE: SHALL last one cycle, then go to IDLE; new requests SHALL be accepted only in IDLE.
REQ-029 Latency for a never-busy channel: request in cycle T; strobe in T+1; capture in T+2; halt low in T+3.
REQ-030 A 16-bit stall counter SHALL clear on entry to ISSUE and increment each cycle in ISSUE/WAIT; on reaching TIMEOUT, SHALL go to DONE, pulse cpu_err_o and load cpu_rdata_o with ERR_DATA (reads only).
REQ-031 cpu_rdata_o SHALL hold its value until the next read completes; writes SHALL not alter it.
REQ-032 ch_addr_o and ch_data_o SHALL hold latched values between transactions.
REQ-033 At most one bit of ch_we_o|ch_re_o SHALL be high in any cycle.

Reset
REQ-034 reset_i low SHALL asynchronously force state IDLE and set all outputs to 0, with the counter and latches cleared.
REQ-035 Reset mid-transaction SHALL drop strobes and halt immediately, and SHALL abandon the transaction with no error pulse.

Structure
REQ-036 cpu_reg_package SHALL hold typedef bridge_state_t and constant ERR_DATA = 32'hDEAD_BEEF.
REQ-037 Hit/channel decode SHALL be a sub-module bus_rv32_ch_decode, parametrised on NUM_CH, ADDR_W, BASE_ADDR and SEL_LSB.

Verification
REQ-038 Read 0x9100, ch1 never busy, ch_rdata_i[1]=0x1234_5678 -> ch_re_o=4'b0010 in T+1; cpu_rdata_o=0x1234_5678 and halt low in T+3.
REQ-039 Write 0x9300 with data 0xA5A5_A5A5, ch3 busy for 5 cycles after the strobe -> ch_we_o=4'b1000 for one cycle; halt high T..T+7; no error.
REQ-040 Read 0x8000 (miss) -> no strobe, halt stays low, cpu_rdata_o unchanged.
REQ-041 TIMEOUT=10, read 0x9000 with ch0 busy permanently -> cpu_err_o pulse in DONE; cpu_rdata_o=0xDEAD_BEEF; no ch_re_o strobe.
REQ-042 cpu_we_i and cpu_re_i both high to 0x9200 -> write strobe on ch2 only, cpu_rdata_o unchanged.
REQ-043 reset_i low during WAIT -> all outputs 0 within the same cycle; after release, the next read to 0x9100 completes normally.
